// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues memory reads at fetch_pc, latches the returned
// word into IR and holds it until the control unit acknowledges or redirects.
module instr_fetch #(
    parameter int          MEM_LAT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        instr_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ISSUE,
        ST_WAIT,
        ST_LATCH,
        ST_HOLD
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        redirect;
    logic        unused_pc_bits;

    // A redirect wins over everything except the post-reset settling cycle.
    assign redirect       = pc_load && (state_q != ST_RESET);
    assign unused_pc_bits = ^pc_next[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RESET;
            fetch_pc_q    <= RESET_PC;
            ir_q          <= 32'h0;
            instr_pc_q    <= 32'h0;
            fetch_count_q <= 32'h0;
            lat_cnt_q     <= 4'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            ir_q          <= ir_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
            lat_cnt_q     <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_ISSUE;
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_ISSUE;
                ST_ISSUE: state_d = (MEM_LAT == 1) ? ST_LATCH : ST_WAIT;
                ST_WAIT:  if (lat_cnt_q <= 4'd1) state_d = ST_LATCH;
                ST_LATCH: state_d = ST_HOLD;
                ST_HOLD:  if (instr_ack) state_d = ST_ISSUE;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        ir_d          = ir_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;
        lat_cnt_d     = lat_cnt_q;
        if (redirect) begin
            fetch_pc_d = {pc_next[31:2], 2'b00};
        end else begin
            case (state_q)
                ST_ISSUE: lat_cnt_d = LAT_M1;
                ST_WAIT:  lat_cnt_d = lat_cnt_q - 4'd1;
                ST_LATCH: begin
                    ir_d          = mem_rdata;
                    instr_pc_d    = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_ISSUE, ST_WAIT, ST_LATCH: mem_rd = 1'b1;
            ST_HOLD:                     instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr    = fetch_pc_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign fetch_count = fetch_count_q;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign shamt       = ir_q[10:6];
    assign funct       = ir_q[5:0];
    assign imm16       = ir_q[15:0];
    assign jaddr       = ir_q[25:0];

endmodule
